// File: rtl/s3_axi_arbiter_if.sv
// AXI-Lite bus between the two-client arbiter (master) and the s3 register wrapper (slave).
interface s3_axi_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RESP_WIDTH = 3
) ();
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [RESP_WIDTH-1:0] bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [RESP_WIDTH-1:0] rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/s3_axi_arbiter.sv
// Two-client round-robin arbiter sequencing single-beat AXI-Lite reads/writes
// onto the shared s3 slave port, returning data/response with a one-cycle ack.
module s3_axi_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RESP_WIDTH = 3
) (
  input  logic                    s3_axi_aclk,
  input  logic                    s3_axi_areset,
  input  logic                    c0_req,
  input  logic                    c0_we,
  input  logic [ADDR_WIDTH-1:0]   c0_addr,
  input  logic [DATA_WIDTH-1:0]   c0_wdata,
  input  logic [DATA_WIDTH/8-1:0] c0_wstrb,
  output logic                    c0_ack,
  output logic [DATA_WIDTH-1:0]   c0_rdata,
  output logic [RESP_WIDTH-1:0]   c0_resp,
  input  logic                    c1_req,
  input  logic                    c1_we,
  input  logic [ADDR_WIDTH-1:0]   c1_addr,
  input  logic [DATA_WIDTH-1:0]   c1_wdata,
  input  logic [DATA_WIDTH/8-1:0] c1_wstrb,
  output logic                    c1_ack,
  output logic [DATA_WIDTH-1:0]   c1_rdata,
  output logic [RESP_WIDTH-1:0]   c1_resp,
  s3_axi_arbiter_if.master        m3_axi
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, DONE} state_t;

  state_t state;
  logic   grant;       // client owning the current transaction
  logic   last_grant;  // client granted most recently

  logic                  pick_c;
  logic                  sel_we_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;
  logic [DATA_WIDTH-1:0] sel_wdata_c;
  logic [STRB_WIDTH-1:0] sel_wstrb_c;
  logic                  aw_done_c;
  logic                  w_done_c;
  logic                  rsp_done_c;
  logic [DATA_WIDTH-1:0] rsp_data_c;
  logic [RESP_WIDTH-1:0] rsp_resp_c;

  // Round-robin pick: on a tie the client not granted last wins.
  always_comb begin
    pick_c = c1_req;
    if (c0_req && c1_req) pick_c = ~last_grant;
    sel_we_c    = pick_c ? c1_we    : c0_we;
    sel_addr_c  = pick_c ? c1_addr  : c0_addr;
    sel_wdata_c = pick_c ? c1_wdata : c0_wdata;
    sel_wstrb_c = pick_c ? c1_wstrb : c0_wstrb;
  end

  // Channel completion and response selection for the current state.
  always_comb begin
    aw_done_c  = !m3_axi.awvalid || m3_axi.awready;
    w_done_c   = !m3_axi.wvalid  || m3_axi.wready;
    rsp_done_c = 1'b0;
    rsp_data_c = '0;
    rsp_resp_c = '0;
    if (state == WRESP) begin
      rsp_done_c = m3_axi.bvalid;
      rsp_resp_c = m3_axi.bresp;
    end else if (state == RDATA) begin
      rsp_done_c = m3_axi.rvalid;
      rsp_data_c = m3_axi.rdata;
      rsp_resp_c = m3_axi.rresp;
    end
  end

  always_ff @(posedge s3_axi_aclk) begin
    if (s3_axi_areset) begin
      state          <= IDLE;
      grant          <= 1'b0;
      last_grant     <= 1'b1;
      m3_axi.awaddr  <= '0;
      m3_axi.awvalid <= 1'b0;
      m3_axi.wdata   <= '0;
      m3_axi.wstrb   <= '0;
      m3_axi.wvalid  <= 1'b0;
      m3_axi.bready  <= 1'b0;
      m3_axi.araddr  <= '0;
      m3_axi.arvalid <= 1'b0;
      m3_axi.rready  <= 1'b0;
      c0_ack         <= 1'b0;
      c0_rdata       <= '0;
      c0_resp        <= '0;
      c1_ack         <= 1'b0;
      c1_rdata       <= '0;
      c1_resp        <= '0;
    end else begin
      c0_ack <= 1'b0;
      c1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (c0_req || c1_req) begin
            grant      <= pick_c;
            last_grant <= pick_c;
            if (sel_we_c) begin
              m3_axi.awaddr  <= sel_addr_c;
              m3_axi.wdata   <= sel_wdata_c;
              m3_axi.wstrb   <= sel_wstrb_c;
              m3_axi.awvalid <= 1'b1;
              m3_axi.wvalid  <= 1'b1;
              state          <= WRITE;
            end else begin
              m3_axi.araddr  <= sel_addr_c;
              m3_axi.arvalid <= 1'b1;
              state          <= READ;
            end
          end
        end
        WRITE: begin
          // AW and W retire independently; move on once both are accepted.
          if (m3_axi.awready) m3_axi.awvalid <= 1'b0;
          if (m3_axi.wready)  m3_axi.wvalid  <= 1'b0;
          if (aw_done_c && w_done_c) begin
            m3_axi.bready <= 1'b1;
            state         <= WRESP;
          end
        end
        WRESP: begin
          if (m3_axi.bvalid) begin
            m3_axi.bready <= 1'b0;
            state         <= DONE;
          end
        end
        READ: begin
          if (m3_axi.arready) begin
            m3_axi.arvalid <= 1'b0;
            m3_axi.rready  <= 1'b1;
            state          <= RDATA;
          end
        end
        RDATA: begin
          if (m3_axi.rvalid) begin
            m3_axi.rready <= 1'b0;
            state         <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Response lands on the granted client together with its ack pulse.
      if (rsp_done_c) begin
        if (grant) begin
          c1_ack   <= 1'b1;
          c1_rdata <= rsp_data_c;
          c1_resp  <= rsp_resp_c;
        end else begin
          c0_ack   <= 1'b1;
          c0_rdata <= rsp_data_c;
          c0_resp  <= rsp_resp_c;
        end
      end
    end
  end
endmodule

// File: tb/tb_s3_axi_arbiter.sv
// Self-checking bench for s3_axi_arbiter: vector table, random transactions
// against a latency/data model, and hand sequences for reset and round-robin.
module tb_s3_axi_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned RW = 3;
  localparam int unsigned SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          c0_req = 1'b0, c0_we = 1'b0, c0_ack;
  logic [AW-1:0] c0_addr = '0;
  logic [DW-1:0] c0_wdata = '0, c0_rdata;
  logic [SW-1:0] c0_wstrb = '0;
  logic [RW-1:0] c0_resp;
  logic          c1_req = 1'b0, c1_we = 1'b0, c1_ack;
  logic [AW-1:0] c1_addr = '0;
  logic [DW-1:0] c1_wdata = '0, c1_rdata;
  logic [SW-1:0] c1_wstrb = '0;
  logic [RW-1:0] c1_resp;

  s3_axi_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) bus ();

  s3_axi_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) dut (
    .s3_axi_aclk(clk), .s3_axi_areset(rst),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_wstrb(c0_wstrb), .c0_ack(c0_ack), .c0_rdata(c0_rdata), .c0_resp(c0_resp),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_wstrb(c1_wstrb), .c1_ack(c1_ack), .c1_rdata(c1_rdata), .c1_resp(c1_resp),
    .m3_axi(bus.master)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave behaviour knobs and observations
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [RW-1:0] s_bresp = '0, s_rresp = '0;
  logic [DW-1:0] s_rdata = '0;
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, aw_only = 0;
  logic [AW-1:0] cap_awaddr = '0, cap_araddr = '0;
  logic [DW-1:0] cap_wdata = '0;
  logic [SW-1:0] cap_wstrb = '0;

  // Slave model: readies/response valids raised after a programmable number of
  // waiting cycles; handshakes are recorded in the cycle they will complete.
  initial begin
    int awc, wc, bc, arc, rc;
    awc = 0; wc = 0; bc = 0; arc = 0; rc = 0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = '0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        awc = 0; wc = 0; bc = 0; arc = 0; rc = 0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
        bus.arready = 1'b0; bus.rvalid = 1'b0;
      end else begin
        if (bus.awvalid) begin bus.awready = (awc >= aw_dly); awc++; end
        else begin bus.awready = 1'b0; awc = 0; end
        if (bus.wvalid) begin bus.wready = (wc >= w_dly); wc++; end
        else begin bus.wready = 1'b0; wc = 0; end
        if (bus.arvalid) begin bus.arready = (arc >= ar_dly); arc++; end
        else begin bus.arready = 1'b0; arc = 0; end
        if (bus.bready) begin bus.bvalid = (bc >= b_dly); bc++; end
        else begin bus.bvalid = 1'b0; bc = 0; end
        if (bus.rready) begin bus.rvalid = (rc >= r_dly); rc++; end
        else begin bus.rvalid = 1'b0; rc = 0; end
        bus.bresp = bus.bvalid ? s_bresp : ~s_bresp;
        bus.rresp = bus.rvalid ? s_rresp : ~s_rresp;
        bus.rdata = bus.rvalid ? s_rdata : ~s_rdata;
        if (bus.awvalid && !bus.wvalid) aw_only++;
        if (bus.awvalid && bus.awready) begin n_aw++; cap_awaddr = bus.awaddr; end
        if (bus.wvalid && bus.wready) begin n_w++; cap_wdata = bus.wdata; cap_wstrb = bus.wstrb; end
        if (bus.arvalid && bus.arready) begin n_ar++; cap_araddr = bus.araddr; end
        if (bus.bvalid && bus.bready) n_b++;
        if (bus.rvalid && bus.rready) n_r++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected last response seen by each client (outputs hold between acks)
  logic [DW-1:0] last_rd[2];
  logic [RW-1:0] last_rs[2];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; c0_req = 1'b0; c1_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0; last_rs[0] = '0; last_rs[1] = '0;
  endtask

  // One single-client transaction from an idle DUT; client inputs are
  // scrambled once granted to prove the bus uses latched copies.
  task automatic run_txn(input string tag, input bit c, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [SW-1:0] ws, input int exp_lat,
                         input logic [DW-1:0] exp_rd, input logic [RW-1:0] exp_rs,
                         input int exp_aw_only);
    int lat;
    bit got, other;
    logic [DW-1:0] rd;
    logic [RW-1:0] rs;
    @(negedge clk);
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; aw_only = 0;
    if (c == 1'b0) begin c0_we = we; c0_addr = addr; c0_wdata = wd; c0_wstrb = ws; c0_req = 1'b1; end
    else begin c1_we = we; c1_addr = addr; c1_wdata = wd; c1_wstrb = ws; c1_req = 1'b1; end
    lat = 0; got = 1'b0; other = 1'b0; rd = '0; rs = '0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        if (c == 1'b0) begin c0_we = ~we; c0_addr = ~addr; c0_wdata = ~wd; c0_wstrb = ~ws; end
        else begin c1_we = ~we; c1_addr = ~addr; c1_wdata = ~wd; c1_wstrb = ~ws; end
      end
      if ((c == 1'b0) ? c1_ack : c0_ack) other = 1'b1;
      if ((c == 1'b0) ? c0_ack : c1_ack) begin
        got = 1'b1;
        rd = (c == 1'b0) ? c0_rdata : c1_rdata;
        rs = (c == 1'b0) ? c0_resp : c1_resp;
        if (c == 1'b0) c0_req = 1'b0; else c1_req = 1'b0;
      end
    end
    if (!got) begin
      c0_req = 1'b0; c1_req = 1'b0;
      lat = -1;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " rdata"}, 64'(rd), 64'(exp_rd));
    chk({tag, " resp"}, 64'(rs), 64'(exp_rs));
    chk({tag, " other ack"}, 64'(other), 64'd0);
    chk({tag, " other rdata"}, 64'((c == 1'b0) ? c1_rdata : c0_rdata), 64'(last_rd[~c]));
    chk({tag, " other resp"}, 64'((c == 1'b0) ? c1_resp : c0_resp), 64'(last_rs[~c]));
    chk({tag, " aw only cycles"}, 64'(aw_only), 64'(exp_aw_only));
    if (we) begin
      chk({tag, " hs counts"}, 64'({4'(n_aw), 4'(n_w), 4'(n_b), 4'(n_ar), 4'(n_r)}), 64'h11100);
      chk({tag, " awaddr"}, 64'(cap_awaddr), 64'(addr));
      chk({tag, " wdata/wstrb"}, {24'(cap_wstrb), 40'(cap_wdata)}, {24'(ws), 40'(wd)});
    end else begin
      chk({tag, " hs counts"}, 64'({4'(n_aw), 4'(n_w), 4'(n_b), 4'(n_ar), 4'(n_r)}), 64'h00011);
      chk({tag, " araddr"}, 64'(cap_araddr), 64'(addr));
    end
    last_rd[c] = exp_rd;
    last_rs[c] = exp_rs;
  endtask

  typedef struct {
    bit            c;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [SW-1:0] ws;
    int            aw, w, b, ar, r;
    logic [RW-1:0] resp;
    logic [DW-1:0] rdata;
    int            exp_lat;
    logic [DW-1:0] exp_rd;
    logic [RW-1:0] exp_rs;
    int            exp_aw_only;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int grants[$];
    int times[$];
    int hit;
    bit found;

    vecs[0] = '{1'b0, 1'b1, 8'h00, 32'd25,       4'hF, 0, 0, 0, 0, 0, 3'b000, 32'h0,        3, 32'h0,        3'b000, 0};
    vecs[1] = '{1'b1, 1'b0, 8'h08, 32'h0,        4'h0, 0, 0, 0, 0, 3, 3'b000, 32'hDEADBEEF, 6, 32'hDEADBEEF, 3'b000, 0};
    vecs[2] = '{1'b0, 1'b1, 8'h10, 32'h1234,     4'h3, 4, 2, 0, 0, 0, 3'b000, 32'h0,        7, 32'h0,        3'b000, 2};
    vecs[3] = '{1'b1, 1'b1, 8'h0C, 32'hCAFE,     4'hF, 0, 0, 0, 0, 0, 3'b010, 32'h77,       3, 32'h0,        3'b010, 0};
    vecs[4] = '{1'b0, 1'b0, 8'h04, 32'h0,        4'h0, 0, 0, 0, 2, 1, 3'b011, 32'hA5A55A5A, 6, 32'hA5A55A5A, 3'b011, 0};
    vecs[5] = '{1'b1, 1'b1, 8'hFC, 32'hFFFFFFFF, 4'h8, 0, 3, 2, 0, 0, 3'b001, 32'h0,        8, 32'h0,        3'b001, 0};

    // Reset values
    do_reset();
    chk("reset acks/valids/readies",
        64'({c0_ack, c1_ack, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}), 64'd0);
    chk("reset bus addr/strb", 64'({bus.awaddr, bus.araddr, bus.wstrb}), 64'd0);
    chk("reset wdata", 64'(bus.wdata), 64'd0);
    chk("reset client data", {c0_rdata, c1_rdata}, 64'd0);
    chk("reset client resp", 64'({c0_resp, c1_resp}), 64'd0);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      aw_dly = vecs[i].aw; w_dly = vecs[i].w; b_dly = vecs[i].b;
      ar_dly = vecs[i].ar; r_dly = vecs[i].r;
      s_bresp = vecs[i].resp; s_rresp = vecs[i].resp; s_rdata = vecs[i].rdata;
      run_txn($sformatf("vec%0d", i), vecs[i].c, vecs[i].we, vecs[i].addr, vecs[i].wd,
              vecs[i].ws, vecs[i].exp_lat, vecs[i].exp_rd, vecs[i].exp_rs, vecs[i].exp_aw_only);
    end

    // Random transactions checked against the timing/data model
    for (int i = 0; i < 40; i++) begin
      bit c;
      logic we;
      int lat, ao;
      c = 1'($urandom_range(1, 0));
      we = 1'($urandom_range(1, 0));
      aw_dly = $urandom_range(3, 0); w_dly = $urandom_range(3, 0); b_dly = $urandom_range(3, 0);
      ar_dly = $urandom_range(3, 0); r_dly = $urandom_range(3, 0);
      s_bresp = RW'($urandom); s_rresp = RW'($urandom); s_rdata = $urandom;
      lat = we ? 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly : 3 + ar_dly + r_dly;
      ao = (we && aw_dly > w_dly) ? aw_dly - w_dly : 0;
      run_txn($sformatf("rnd%0d", i), c, we, AW'($urandom), DW'($urandom), SW'($urandom),
              lat, we ? '0 : s_rdata, we ? s_bresp : s_rresp, ao);
    end

    // Reset while waiting in RDATA: transaction abandoned, no ack
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 6;
    s_rdata = 32'h0BADF00D; s_rresp = 3'b000; s_bresp = 3'b000;
    @(negedge clk);
    c0_we = 1'b0; c0_addr = 8'h14; c0_req = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (bus.rready) found = 1'b1;
    end
    chk("rst-in-rdata reached rready", 64'(found), 64'd1);
    rst = 1'b1; c0_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst-in-rdata readies/valids low",
        64'({bus.rready, bus.arvalid, bus.awvalid, bus.wvalid, bus.bready}), 64'd0);
    hit = 0;
    for (int k = 0; k < 8; k++) begin
      if (c0_ack || c1_ack) hit++;
      @(negedge clk);
    end
    chk("rst-in-rdata no ack", 64'(hit), 64'd0);
    chk("rst-in-rdata outputs cleared", {c0_rdata, 29'd0, c0_resp}, 64'd0);

    // Fresh tie after reset: client 0 read must win over client 1 write
    r_dly = 0; s_rdata = 32'h11112222; s_rresp = 3'b000;
    c0_we = 1'b0; c0_addr = 8'h20; c0_req = 1'b1;
    c1_we = 1'b1; c1_addr = 8'h24; c1_wdata = 32'h5; c1_wstrb = 4'hF; c1_req = 1'b1;
    hit = -1;
    for (int k = 1; k <= 20 && hit < 0; k++) begin
      @(negedge clk);
      if (c0_ack || c1_ack) begin
        hit = k;
        chk("tie winner acks", 64'({c1_ack, c0_ack}), 64'b01);
        chk("tie winner rdata", 64'(c0_rdata), 64'h11112222);
        c0_req = 1'b0;
      end
    end
    chk("tie winner latency", 64'(hit), 64'd3);
    hit = -1;
    for (int k = 1; k <= 20 && hit < 0; k++) begin
      @(negedge clk);
      if (c1_ack) begin hit = k; c1_req = 1'b0; end
    end
    chk("tie loser latency", 64'(hit), 64'd4);
    c0_req = 1'b0; c1_req = 1'b0;

    // Both clients writing continuously: grants alternate, 4 cycles apart
    do_reset();
    c0_we = 1'b1; c0_addr = 8'h30; c0_wdata = 32'hA; c0_wstrb = 4'hF; c0_req = 1'b1;
    c1_we = 1'b1; c1_addr = 8'h34; c1_wdata = 32'hB; c1_wstrb = 4'hF; c1_req = 1'b1;
    for (int k = 1; k <= 80 && grants.size() < 6; k++) begin
      @(negedge clk);
      if (c0_ack) begin grants.push_back(0); times.push_back(k); c0_req = 1'b0; end
      else c0_req = 1'b1;
      if (c1_ack) begin grants.push_back(1); times.push_back(k); c1_req = 1'b0; end
      else c1_req = 1'b1;
    end
    c0_req = 1'b0; c1_req = 1'b0;
    chk("b2b ack count", 64'(grants.size()), 64'd6);
    for (int i = 0; i < grants.size(); i++)
      chk($sformatf("b2b grant%0d", i), 64'(grants[i]), 64'(i % 2));
    for (int i = 1; i < times.size(); i++)
      chk($sformatf("b2b gap%0d", i), 64'(times[i] - times[i-1]), 64'd4);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
